alu_seq: RTL

Parametrised, registered successor to the 8-bit combinational ALU. Adds a configurable datapath width, a 4-bit opcode space with shift and multi-cycle unsigned multiply operations, and a persistent carry/zero/negative/overflow flag register. The stored carry feeds ADDC/SUBC, so there is no external carry input. A start/busy/done handshake lets the datapath controller issue operations and detect completion.

---
 rtl/alu_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with persistent C/Z/N/V flags, shifts and a shift-add multiplier.
// Single-cycle ops complete in one clock; MUL keeps busy high for WIDTH clocks.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int M  = WIDTH - 1;
  localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB = 4'd2,  OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_NAND = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_SAR = 4'd10, OP_MUL  = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_q, out_d, hi_q, hi_d;
  logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     wide, step;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH-1:0]   a, b, r;
  logic               cin, big, upd;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    out_d   = out_q;
    hi_d    = hi_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    a       = alu_in1;
    b       = alu_in2;
    r       = '0;
    wide    = '0;
    upd     = 1'b0;
    cin     = opcode[0] & c_q;  // ADDC and SUBC are the odd arithmetic opcodes
    big     = alu_in2 > WV;
    // Upper half accumulates the multiplicand; the lower half shifts the multiplier out.
    step    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nx = {step, prod_q[WIDTH-1:1]};

    case (state_q)
      S_MUL: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          out_d   = prod_nx[WIDTH-1:0];
          hi_d    = prod_nx[2*WIDTH-1:WIDTH];
          c_d     = |prod_nx[2*WIDTH-1:WIDTH];
          v_d     = |prod_nx[2*WIDTH-1:WIDTH];
          z_d     = ~|prod_nx;
          n_d     = prod_nx[2*WIDTH-1];
        end
      end
      default: begin
        if (start) begin
          done_d = 1'b1;
          upd    = 1'b1;
          case (opcode)
            OP_ADD, OP_ADDC: begin
              wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
              r    = wide[WIDTH-1:0];
              c_d  = wide[WIDTH];
              v_d  = (a[M] == b[M]) && (r[M] != a[M]);
            end
            OP_SUB, OP_SUBC: begin
              wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
              r    = wide[WIDTH-1:0];
              c_d  = wide[WIDTH];
              v_d  = (a[M] != b[M]) && (r[M] != a[M]);
            end
            OP_AND:  begin r = a & b;    v_d = 1'b0; end
            OP_OR:   begin r = a | b;    v_d = 1'b0; end
            OP_XOR:  begin r = a ^ b;    v_d = 1'b0; end
            OP_NAND: begin r = ~(a & b); v_d = 1'b0; end
            OP_SHL, OP_SHR, OP_SAR: begin
              v_d = 1'b0;
              if (b == '0) begin
                r = a;
              end else if (big) begin
                r   = (opcode == OP_SAR) ? {WIDTH{a[M]}} : '0;
                c_d = (opcode == OP_SAR) & a[M];
              end else if (opcode == OP_SHL) begin
                wide = {1'b0, a} << b;
                r    = wide[WIDTH-1:0];
                c_d  = wide[WIDTH];
              end else begin
                // A guard bit below the LSB catches the last bit shifted out.
                wide = (opcode == OP_SAR) ? $signed({a, 1'b0}) >>> b : {a, 1'b0} >> b;
                r    = wide[WIDTH:1];
                c_d  = wide[0];
              end
            end
            OP_MUL: begin
              upd     = 1'b0;
              done_d  = 1'b0;
              state_d = S_MUL;
              mcand_d = a;
              prod_d  = {{WIDTH{1'b0}}, b};
              cnt_d   = '0;
            end
            default: upd = 1'b0;
          endcase
          if (upd) begin
            out_d = r;
            hi_d  = '0;
            z_d   = ~|r;
            n_d   = r[M];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == S_MUL);
  assign done       = done_q;
  assign alu_out    = out_q;
  assign alu_out_hi = hi_q;
  assign carry      = c_q;
  assign zero       = z_q;
  assign neg        = n_q;
  assign ovf        = v_q;
endmodule
